// File: rtl/datapath_pkg.sv
// Shared constants and select encodings for the single-bus CPU datapath.
package datapath_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [3:0] {
    BusNone, BusPc, BusZlo, BusZhi, BusMdr, BusR1, BusR2, BusR3, BusHi
  } bus_sel_e;

  typedef enum logic [2:0] {
    OpNone, OpIncPc, OpAnd, OpOr, OpAdd, OpSub, OpSrl, OpShl
  } alu_op_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A comes from Y, B from the bus; upper half of the result is always zero.
// Shifts are only built when DATAPATH_SHIFT_EN is defined.
module cpu_alu #(
  parameter int unsigned WIDTH = datapath_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  datapath_pkg::alu_op_e op,
  output logic [2*WIDTH-1:0]   result
);
  import datapath_pkg::*;

  logic [WIDTH-1:0] lo;

  always_comb begin
    lo = b;
    case (op)
      OpIncPc: lo = b + WIDTH'(1);
      OpAnd:   lo = a & b;
      OpOr:    lo = a | b;
      OpAdd:   lo = a + b;
      OpSub:   lo = a - b;
`ifdef DATAPATH_SHIFT_EN
      OpSrl:   lo = a >> b[4:0];
      OpShl:   lo = a << b[4:0];
`endif
      // OpNone passes the bus through so a bare Zin latches {0, bus}
      default: lo = b;
    endcase
  end

  assign result = {{WIDTH{1'b0}}, lo};

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, priority bus mux, MDR input mux and 64-bit Z.
// Optional SRL/SHL support is enabled with DATAPATH_SHIFT_EN.
module cpu_datapath #(
  parameter int unsigned WIDTH = datapath_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             ZHighout,
  input  logic             MDRout,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             HIout,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             HIin,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             Read,
  input  logic             AND,
  input  logic             OR,
  input  logic             ADD,
  input  logic             SUB,
  input  logic             IncPc,
  input  logic             SRL,
  input  logic             SHL,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] MARaddr,
  output logic [WIDTH-1:0] IRout
);
  import datapath_pkg::*;

  logic [WIDTH-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, r1_q, r2_q, r3_q;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   bus;
  bus_sel_e           bus_sel;
  alu_op_e            alu_op;
  logic               z_load;

  always_comb begin
    bus_sel = BusNone;
    if      (PCout)    bus_sel = BusPc;
    else if (Zlowout)  bus_sel = BusZlo;
    else if (ZHighout) bus_sel = BusZhi;
    else if (MDRout)   bus_sel = BusMdr;
    else if (R1out)    bus_sel = BusR1;
    else if (R2out)    bus_sel = BusR2;
    else if (R3out)    bus_sel = BusR3;
    else if (HIout)    bus_sel = BusHi;
  end

  always_comb begin
    bus = '0;
    case (bus_sel)
      BusPc:   bus = pc_q;
      BusZlo:  bus = z_q[WIDTH-1:0];
      BusZhi:  bus = z_q[2*WIDTH-1:WIDTH];
      BusMdr:  bus = mdr_q;
      BusR1:   bus = r1_q;
      BusR2:   bus = r2_q;
      BusR3:   bus = r3_q;
      BusHi:   bus = hi_q;
      default: bus = '0;
    endcase
  end

  always_comb begin
    alu_op = OpNone;
    if      (IncPc) alu_op = OpIncPc;
    else if (AND)   alu_op = OpAnd;
    else if (OR)    alu_op = OpOr;
    else if (ADD)   alu_op = OpAdd;
    else if (SUB)   alu_op = OpSub;
`ifdef DATAPATH_SHIFT_EN
    else if (SRL)   alu_op = OpSrl;
    else if (SHL)   alu_op = OpShl;
`endif
  end

`ifndef DATAPATH_SHIFT_EN
  logic unused_shift;
  assign unused_shift = SRL | SHL;
`endif

  cpu_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (y_q),
    .b      (bus),
    .op     (alu_op),
    .result (z_d)
  );

  // Any ALU op writes Z even without Zin
  assign z_load = Zin | (alu_op != OpNone);

  always_ff @(posedge clock) begin
    if (!clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
    end else begin
      if (PCin)   pc_q  <= bus;
      if (IRin)   ir_q  <= bus;
      if (MARin)  mar_q <= bus;
      if (MDRin)  mdr_q <= Read ? Mdatain : bus;
      if (Yin)    y_q   <= bus;
      if (z_load) z_q   <= z_d;
      if (HIin)   hi_q  <= bus;
      if (R1in)   r1_q  <= bus;
      if (R2in)   r2_q  <= bus;
      if (R3in)   r3_q  <= bus;
    end
  end

  assign BusMuxOut = bus;
  assign MARaddr   = mar_q;
  assign IRout     = ir_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized control words
// checked against a register-level behavioural model.
module tb_cpu_datapath;

  logic        clock;
  logic        clear;
  logic [31:0] Mdatain;
  logic        PCout, Zlowout, ZHighout, MDRout, R1out, R2out, R3out, HIout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, R1in, R2in, R3in;
  logic        Read, AND, OR, ADD, SUB, IncPc, SRL, SHL;
  logic [31:0] BusMuxOut, MARaddr, IRout;

  cpu_datapath dut (
    .clock     (clock),
    .clear     (clear),
    .Mdatain   (Mdatain),
    .PCout     (PCout),
    .Zlowout   (Zlowout),
    .ZHighout  (ZHighout),
    .MDRout    (MDRout),
    .R1out     (R1out),
    .R2out     (R2out),
    .R3out     (R3out),
    .HIout     (HIout),
    .PCin      (PCin),
    .IRin      (IRin),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .HIin      (HIin),
    .R1in      (R1in),
    .R2in      (R2in),
    .R3in      (R3in),
    .Read      (Read),
    .AND       (AND),
    .OR        (OR),
    .ADD       (ADD),
    .SUB       (SUB),
    .IncPc     (IncPc),
    .SRL       (SRL),
    .SHL       (SHL),
    .BusMuxOut (BusMuxOut),
    .MARaddr   (MARaddr),
    .IRout     (IRout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bus drive enables, index 0 is highest priority
  localparam logic [7:0] O_PC = 8'h01, O_ZLO = 8'h02, O_ZHI = 8'h04, O_MDR = 8'h08;
  localparam logic [7:0] O_R1 = 8'h10, O_R2 = 8'h20, O_R3 = 8'h40, O_HI = 8'h80;
  localparam logic [9:0] I_PC = 10'h001, I_IR = 10'h002, I_MAR = 10'h004, I_MDR = 10'h008;
  localparam logic [9:0] I_Y = 10'h010, I_Z = 10'h020, I_HI = 10'h040;
  localparam logic [9:0] I_R1 = 10'h080, I_R2 = 10'h100, I_R3 = 10'h200;
  // ALU op selects, index 0 is highest priority
  localparam logic [6:0] A_INC = 7'h01, A_AND = 7'h02, A_OR = 7'h04, A_ADD = 7'h08;
  localparam logic [6:0] A_SUB = 7'h10, A_SRL = 7'h20, A_SHL = 7'h40;

`ifdef DATAPATH_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_r1, m_r2, m_r3;
  logic [63:0] m_z;
  logic [31:0] last_bus;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_bus(input logic [7:0] outs);
    logic [31:0] src [8];
    src[0] = m_pc;  src[1] = m_z[31:0]; src[2] = m_z[63:32]; src[3] = m_mdr;
    src[4] = m_r1;  src[5] = m_r2;      src[6] = m_r3;       src[7] = m_hi;
    for (int i = 0; i < 8; i++) if (outs[i]) return src[i];
    return 32'h0;
  endfunction

  function automatic int model_op(input logic [6:0] ops);
    for (int i = 0; i < 7; i++) begin
      if (ops[i] && (i < 5 || ShiftEn)) return i;
    end
    return -1;
  endfunction

  function automatic logic [63:0] model_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] lo;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      0:       lo = b + 32'd1;
      1:       lo = a & b;
      2:       lo = a | b;
      3:       lo = a + b;
      4:       lo = a - b;
      5:       lo = a >> sh;
      6:       lo = a << sh;
      default: lo = b;
    endcase
    return {32'h0, lo};
  endfunction

  // One clock: drive controls, check bus at negedge, update model, check MAR/IR after the edge
  task automatic step(input logic clr, input logic [7:0] outs, input logic [9:0] ins,
                      input logic rd, input logic [6:0] ops, input logic [31:0] md);
    logic [31:0] eb;
    logic [63:0] ez;
    int          op;
    clear   = clr;
    Mdatain = md;
    Read    = rd;
    {HIout, R3out, R2out, R1out, MDRout, ZHighout, Zlowout, PCout} = outs;
    {R3in, R2in, R1in, HIin, Zin, Yin, MDRin, MARin, IRin, PCin}   = ins;
    {SHL, SRL, SUB, ADD, OR, AND, IncPc}                           = ops;
    @(negedge clock);
    eb = model_bus(outs);
    check("bus", {32'h0, BusMuxOut}, {32'h0, eb});
    last_bus = BusMuxOut;
    op = model_op(ops);
    ez = (op >= 0) ? model_alu(op, m_y, eb) : {32'h0, eb};
    if (!clr) begin
      {m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_r1, m_r2, m_r3} = '0;
      m_z = '0;
    end else begin
      if (ins[0]) m_pc  = eb;
      if (ins[1]) m_ir  = eb;
      if (ins[2]) m_mar = eb;
      if (ins[3]) m_mdr = rd ? md : eb;
      if (ins[4]) m_y   = eb;
      if (ins[5] || op >= 0) m_z = ez;
      if (ins[6]) m_hi  = eb;
      if (ins[7]) m_r1  = eb;
      if (ins[8]) m_r2  = eb;
      if (ins[9]) m_r3  = eb;
    end
    @(posedge clock);
    #1;
    check("mar", {32'h0, MARaddr}, {32'h0, m_mar});
    check("ir",  {32'h0, IRout},   {32'h0, m_ir});
  endtask

  initial begin
    logic [7:0] r_outs;
    logic [9:0] r_ins;
    logic [6:0] r_ops;
    {m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_r1, m_r2, m_r3} = '0;
    m_z      = '0;
    last_bus = '0;

    // Reset, load arbitrary values, reset again and read every source back
    step(1'b0, 8'h00, 10'h000, 1'b0, 7'h00, 32'h0);
    step(1'b1, 8'h00, I_MDR, 1'b1, 7'h00, 32'hDEAD_BEEF);
    step(1'b1, O_MDR, 10'h3FF, 1'b0, 7'h00, 32'h0);
    step(1'b0, 8'h00, 10'h000, 1'b0, 7'h00, 32'h0);
    check("rst_mar", {32'h0, MARaddr}, 64'h0);
    check("rst_ir", {32'h0, IRout}, 64'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(1 << i), 10'h000, 1'b0, 7'h00, 32'h0);
      check("rst_src", {32'h0, last_bus}, 64'h0);
    end

    // Memory data into R2/R3/R1; MDR holds while MDRin is low
    step(1'b1, 8'h00, I_MDR, 1'b1, 7'h00, 32'h12);
    step(1'b1, O_MDR, I_R2, 1'b0, 7'h00, 32'h0);
    step(1'b1, 8'h00, 10'h000, 1'b1, 7'h00, 32'h11);
    step(1'b1, O_MDR, 10'h000, 1'b0, 7'h00, 32'h0);
    check("mdr_hold", {32'h0, last_bus}, 64'h12);
    step(1'b1, 8'h00, I_MDR, 1'b1, 7'h00, 32'h01);
    step(1'b1, O_MDR, I_R3, 1'b0, 7'h00, 32'h0);
    step(1'b1, 8'h00, I_MDR, 1'b1, 7'h00, 32'h18);
    step(1'b1, O_MDR, I_R1, 1'b0, 7'h00, 32'h0);
    step(1'b1, O_R2, 10'h000, 1'b0, 7'h00, 32'h0);
    check("r2", {32'h0, last_bus}, 64'h12);
    step(1'b1, O_R3, 10'h000, 1'b0, 7'h00, 32'h0);
    check("r3", {32'h0, last_bus}, 64'h01);
    step(1'b1, O_R1, 10'h000, 1'b0, 7'h00, 32'h0);
    check("r1", {32'h0, last_bus}, 64'h18);

    // AND 0x12 & 0x01 into R1, upper Z into HI
    step(1'b1, O_R2, I_Y, 1'b0, 7'h00, 32'h0);
    step(1'b1, O_R3, 10'h000, 1'b0, A_AND, 32'h0);
    step(1'b1, O_ZLO, I_R1, 1'b0, 7'h00, 32'h0);
    step(1'b1, O_ZHI, I_HI, 1'b0, 7'h00, 32'h0);
    step(1'b1, O_R1, 10'h000, 1'b0, 7'h00, 32'h0);
    check("and_r1", {32'h0, last_bus}, 64'h0);
    step(1'b1, O_HI, 10'h000, 1'b0, 7'h00, 32'h0);
    check("and_hi", {32'h0, last_bus}, 64'h0);

    // Instruction fetch
    step(1'b1, O_PC, I_MAR, 1'b0, A_INC, 32'h0);
    check("fetch_mar", {32'h0, MARaddr}, 64'h0);
    step(1'b1, O_ZLO, I_PC, 1'b0, 7'h00, 32'h0);
    check("fetch_z", {32'h0, last_bus}, 64'h1);
    step(1'b1, 8'h00, I_MDR, 1'b1, 7'h00, 32'h6);
    step(1'b1, O_MDR, I_IR, 1'b0, 7'h00, 32'h0);
    check("fetch_ir", {32'h0, IRout}, 64'h6);
    step(1'b1, O_PC, 10'h000, 1'b0, 7'h00, 32'h0);
    check("fetch_pc", {32'h0, last_bus}, 64'h1);

    // Shifts: Y=0x12, B=1; Z holds 1 beforehand and stays there when shifts are absent
    step(1'b1, O_R2, I_Y, 1'b0, 7'h00, 32'h0);
    step(1'b1, O_R3, 10'h000, 1'b0, A_SRL, 32'h0);
    step(1'b1, O_ZLO, 10'h000, 1'b0, 7'h00, 32'h0);
    check("srl", {32'h0, last_bus}, ShiftEn ? 64'h09 : 64'h01);
    step(1'b1, O_R3, 10'h000, 1'b0, A_SHL, 32'h0);
    step(1'b1, O_ZLO, 10'h000, 1'b0, 7'h00, 32'h0);
    check("shl", {32'h0, last_bus}, ShiftEn ? 64'h24 : 64'h01);

    // Wrap-around ADD/SUB and bus priority
    step(1'b1, 8'h00, I_MDR, 1'b1, 7'h00, 32'hFFFF_FFFF);
    step(1'b1, O_MDR, I_Y, 1'b0, 7'h00, 32'h0);
    step(1'b1, O_R3, 10'h000, 1'b0, A_ADD, 32'h0);
    step(1'b1, O_ZLO, 10'h000, 1'b0, 7'h00, 32'h0);
    check("add_lo", {32'h0, last_bus}, 64'h0);
    step(1'b1, O_ZHI, 10'h000, 1'b0, 7'h00, 32'h0);
    check("add_hi", {32'h0, last_bus}, 64'h0);
    step(1'b1, 8'h00, I_Y, 1'b0, 7'h00, 32'h0);
    step(1'b1, O_R3, 10'h000, 1'b0, A_SUB, 32'h0);
    step(1'b1, O_ZLO, 10'h000, 1'b0, 7'h00, 32'h0);
    check("sub_lo", {32'h0, last_bus}, 64'hFFFF_FFFF);
    step(1'b1, O_PC | O_MDR, 10'h000, 1'b0, 7'h00, 32'h0);
    check("bus_prio", {32'h0, last_bus}, 64'h1);

    // Randomized control words against the model
    for (int n = 0; n < 600; n++) begin
      r_outs = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r_outs = 8'h00;
      r_ins = 10'($urandom);
      r_ops = '0;
      for (int b = 0; b < 7; b++) r_ops[b] = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 59) != 0), r_outs, r_ins, 1'($urandom), r_ops, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
